uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- UART receiver front end for the snack-dispenser controller; sits directly upstream of the packet-assembly FSM.
- Accepts asynchronous 8N1 serial on a single GPIO pin and emits each received byte with a one-cycle valid strobe.
- Oversamples the line, majority-votes each bit, and rejects false starts and framing errors so that corrupted bytes never reach command assembly.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.
- TICK_DIV, CLK_HZ/(BAUD*OVERSAMPLE), clocks per sample tick; integer division, 27 at defaults.

Ports:
- clk, input, 1, system clock; the only clock.
- rst_n, input, 1, reset; synchronous, active-low.
- rx_pin, input, 1, asynchronous serial line; idles high.
- data_out, output, 8, last correctly framed byte; LSB is received first.
- data_ready, output, 1, one-cycle pulse when data_out is updated.
- frame_error, output, 1, one-cycle pulse when the stop bit is sampled low.
- busy, output, 1, high from start-bit detect until the frame completes or aborts.

Behaviour:
- Reset (rst_n low at a clk edge): data_out=0, data_ready=0, frame_error=0, busy=0, FSM=IDLE, tick counter=0, synchroniser flops=1. Reset mid-frame discards the partial byte and produces no pulse.
- Input synchronisation:
  - rx_pin passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
  - A 3-sample majority vote is taken at sample ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit.
- Tick generator:
  - Free-running count 0..TICK_DIV-1; emits a 1-clk tick on wrap.
  - Restarts from 0 on start-bit detect so sampling is phase-aligned to the falling edge.
- FSM states and transitions:
  - IDLE: busy=0. A falling edge on rx_s (previous 1, current 0) goes to START and clears the tick-in-bit count.
  - START: at the majority-vote point, a vote of 1 means a false start/glitch; return to IDLE with no pulse. A vote of 0 continues counting to OVERSAMPLE ticks, then goes to DATA with bit index 0.
  - DATA: at each bit's vote point, shift the voted bit into bit[idx] (LSB first). After OVERSAMPLE ticks, idx increments; after idx 7 completes, go to STOP.
  - STOP, vote = 1: data_out <= assembled byte, data_ready=1 for exactly one clk, then IDLE. The FSM does not wait for the end of the stop bit, which tolerates fast senders.
  - STOP, vote = 0: frame_error=1 for one clk, data_out unchanged, then BREAK.
  - BREAK: wait until rx_s=1, then IDLE. A held-low line (break) produces exactly one frame_error and no repeated frames.
- Timing and latency:
  - data_ready rises within 3 clk of the stop-bit vote point.
  - At defaults: 2 synchroniser clk + 9.5 bits × 432 clk ≈ 4106 clk after the start-bit falling edge.
- Simultaneous events: rst_n overrides everything. data_ready and frame_error are never high in the same cycle.
- Tolerance: at defaults the bit period is 432 clk against an ideal of 434.03 (−0.47%). Total sender/receiver mismatch up to ±3% must decode correctly.
- busy is high in START, DATA, STOP and BREAK.

Decomposition:
- Shared package uart_pkg:
  - localparams for the FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - The DATA_BITS=8 constant.
  - A function computing TICK_DIV from CLK_HZ, BAUD and OVERSAMPLE; a future UART transmitter for status replies reuses it.
- One sub-module, uart_baud_tick: tick counter with a synchronous restart input and a tick output.
- The synchroniser, voter and FSM stay in the top level.

Test Plan:
- Defaults, send 0xA5 at 115200 8N1 -> exactly one data_ready pulse; data_out=0xA5; frame_error never asserted; busy low again within 1 bit time.
- rx_pin low glitch of 200 ns (10 clk) while idle -> no data_ready, no frame_error; FSM back in IDLE before 1 bit time elapses.
- Send 0x3C with stop bit forced 0, then line high -> one frame_error pulse; no data_ready; data_out retains the previous value (0xA5).
- Back-to-back 0x07 then 0x81 with zero idle gap -> two data_ready pulses carrying 0x07 then 0x81; downstream assembles command 0x8107.
- Assert rst_n low for 2 clk during data bit 4 of 0xFF, then send 0x5A -> outputs 0 during and after reset; the only pulse is for 0x5A.
- Sender baud at +3% and −3% (bit periods 421 and 447 clk), bytes 0x00, 0xFF, 0x55 -> all received correctly. Line held low for 20 bit times -> exactly one frame_error, then normal reception of 0x42.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } uart_state_t;

  // Clocks per oversample tick; truncating division, so the bit period runs slightly short.
  function automatic int calc_tick_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..TICK_DIV-1 counter, re-phased by restart.
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (restart || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tick = (count_reg == LAST) && !restart;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, framing checks.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] SAMP_A  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_B  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] VOTE_AT = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_meta, rx_s, rx_prev;
  logic tick, restart, vote, vote_point;

  uart_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     tick_cnt_reg, tick_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 samp_a_reg, samp_a_next, samp_b_reg, samp_b_next;
  logic [7:0]           data_out_reg, data_out_next;
  logic                 data_ready_reg, data_ready_next;
  logic                 frame_error_reg, frame_error_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Third sample is taken live at the vote tick, so no extra latency is added.
  assign vote       = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);
  assign vote_point = tick && (tick_cnt_reg == VOTE_AT);
  assign restart    = (state_reg == IDLE) && rx_prev && !rx_s;

  always_comb begin
    state_next       = state_reg;
    tick_cnt_next    = tick_cnt_reg;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    samp_a_next      = samp_a_reg;
    samp_b_next      = samp_b_reg;
    data_out_next    = data_out_reg;
    data_ready_next  = 1'b0;
    frame_error_next = 1'b0;

    if (tick && tick_cnt_reg == SAMP_A) samp_a_next = rx_s;
    if (tick && tick_cnt_reg == SAMP_B) samp_b_next = rx_s;

    case (state_reg)
      IDLE: begin
        if (restart) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (vote_point && vote) begin
          state_next = IDLE;
        end else if (tick) begin
          if (tick_cnt_reg == BIT_END) begin
            tick_cnt_next = '0;
            bit_idx_next  = '0;
            state_next    = DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (vote_point) shift_next[bit_idx_reg] = vote;
          if (tick_cnt_reg == BIT_END) begin
            tick_cnt_next = '0;
            if (bit_idx_reg == IDX_LAST) state_next = STOP;
            else bit_idx_next = bit_idx_reg + IDX_W'(1);
          end else begin
            tick_cnt_next = tick_cnt_reg + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (vote_point) begin
          if (vote) begin
            data_out_next   = shift_reg;
            data_ready_next = 1'b1;
            state_next      = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = BREAK;
          end
        end else if (tick) begin
          tick_cnt_next = tick_cnt_reg + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      tick_cnt_reg    <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      samp_a_reg      <= 1'b1;
      samp_b_reg      <= 1'b1;
      data_out_reg    <= '0;
      data_ready_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tick_cnt_reg    <= tick_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      samp_a_reg      <= samp_a_next;
      samp_b_reg      <= samp_b_next;
      data_out_reg    <= data_out_next;
      data_ready_reg  <= data_ready_next;
      frame_error_reg <= frame_error_next;
    end
  end

  assign data_out    = data_out_reg;
  assign data_ready  = data_ready_reg;
  assign frame_error = frame_error_reg;
  assign busy        = (state_reg != IDLE);

endmodule
